// File: rtl/updown_mod_counter.sv
// WIDTH-bit up/down modulo counter with programmable terminal value.
// Supports wrap/saturate modes, load, clear, a terminal-count strobe and a sticky overflow flag.
module updown_mod_counter #(
    parameter int unsigned WIDTH     = 8,
    parameter int unsigned RESET_VAL = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             up,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             clear,
    input  logic [WIDTH-1:0] limit,
    input  logic             sat_mode,
    output logic [WIDTH-1:0] q,
    output logic             tc,
    output logic             ovf
);

    localparam logic [WIDTH-1:0] RST_Q = WIDTH'(RESET_VAL);

    logic             at_top;
    logic             at_bot;
    logic             hit;
    logic [WIDTH-1:0] load_q;
    logic [WIDTH-1:0] step_q;
    logic [WIDTH-1:0] q_nxt;
    logic             ovf_nxt;

    // Boundary detection compares before any add/subtract so nothing overflows.
    always_comb begin
        at_top = (q >= limit);
        at_bot = (q == '0);
        hit    = up ? at_top : at_bot;
        tc     = en & ~load & ~clear & ~reset & hit;
    end

    // Clamp loads into the 0..limit range.
    always_comb begin
        load_q = (load_val <= limit) ? load_val : limit;
    end

    // Value taken on an enabled step, including boundary wrap/saturate.
    always_comb begin
        step_q = q;
        if (up) begin
            if (at_top) begin
                step_q = sat_mode ? limit : '0;
            end else begin
                step_q = q + WIDTH'(1);
            end
        end else begin
            if (at_bot) begin
                step_q = sat_mode ? '0 : limit;
            end else begin
                step_q = q - WIDTH'(1);
            end
        end
    end

    // Load > enable > hold; clear and reset are applied in the register.
    always_comb begin
        q_nxt   = q;
        ovf_nxt = ovf;
        if (load) begin
            q_nxt = load_q;
        end else if (en) begin
            q_nxt = step_q;
            if (hit) begin
                ovf_nxt = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            q   <= RST_Q;
            ovf <= 1'b0;
        end else if (clear) begin
            q   <= '0;
            ovf <= 1'b0;
        end else begin
            q   <= q_nxt;
            ovf <= ovf_nxt;
        end
    end

endmodule
